// File: rtl/fifo_rptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rptr_ctrl
//
// Read-side pointer and status controller for the JTAG async FIFO. It runs
// entirely in the read clock domain. It keeps a binary and a Gray-coded read
// pointer, and derives registered empty, fill-level, almost-empty and sticky
// underflow status from the write pointer, which has already been
// synchronised into this domain.
//
// Parameters:
//   ADDR_WIDTH     RAM address bits. Depth is 2**ADDR_WIDTH, and the
//                  pointers are ADDR_WIDTH+1 bits wide.
//   AEMPTY_THRESH  almost_empty asserts when the fill level is <= this value.
//                  Legal range is 0 .. 2**ADDR_WIDTH-1.
//
// Configuration macro: FIFO_RPTR_AEMPTY_EN
//   defined   : the threshold comparator and the almost_empty register are
//               built.
//   undefined : almost_empty is kept as a port and tied to empty.
//
// Ports:
//   rclk          in   read-domain clock
//   r_nrst        in   asynchronous active-low reset
//   rinc          in   read request from the consumer
//   sync_wptr     in   Gray write pointer, synchronised into rclk
//   clr_err       in   synchronous clear of the sticky underflow flag
//   rptr          out  Gray read pointer, sent to the write-domain synchroniser
//   raddr         out  RAM read address (low bits of the binary pointer)
//   empty         out  FIFO empty
//   almost_empty  out  fill level <= AEMPTY_THRESH
//   rcount        out  fill level seen from the read side (0 .. 2**ADDR_WIDTH)
//   underflow     out  sticky; set by a read attempted while empty
//
// All outputs are registered. No combinational path runs from an input to an
// output.
// -----------------------------------------------------------------------------
module fifo_rptr_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  rclk,
  input  logic                  r_nrst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   sync_wptr,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rcount,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] rbin_reg, rbin_next;
  logic [ADDR_WIDTH:0] rptr_reg, rptr_next;
  logic [ADDR_WIDTH:0] rcount_reg, rcount_next;
  logic [ADDR_WIDTH:0] wbin;
  logic                empty_reg, empty_next;
  logic                underflow_reg, underflow_next;
  logic                rd_accept;

  // Gray to binary conversion. Each binary bit is the XOR of all Gray bits
  // at or above it. Every bit is computed directly from sync_wptr rather
  // than chained through its neighbour, so there is no ripple through wbin
  // itself.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
      assign wbin[gi] = ^sync_wptr[ADDR_WIDTH:gi];
    end
  endgenerate

  always_comb begin
    rd_accept      = rinc & ~empty_reg;
    rbin_next      = rbin_reg + PW'(rd_accept);
    rptr_next      = rbin_next ^ (rbin_next >> 1);
    // Full-width compare. The Gray MSB toggles once per RAM lap, so equal
    // pointers can only mean empty, never full.
    empty_next     = (rptr_next == sync_wptr);
    // Modulo subtraction. A write pointer that is a full lap ahead yields
    // 2**ADDR_WIDTH, which still fits in PW bits.
    rcount_next    = wbin - rbin_next;
    // When a clear and a new underflow event land in the same cycle, the
    // set term wins.
    underflow_next = (rinc & empty_reg) | (underflow_reg & ~clr_err);
  end

  always_ff @(posedge rclk or negedge r_nrst) begin
    if (!r_nrst) begin
      rbin_reg      <= '0;
      rptr_reg      <= '0;
      rcount_reg    <= '0;
      empty_reg     <= 1'b1;
      underflow_reg <= 1'b0;
    end else begin
      rbin_reg      <= rbin_next;
      rptr_reg      <= rptr_next;
      rcount_reg    <= rcount_next;
      empty_reg     <= empty_next;
      underflow_reg <= underflow_next;
    end
  end

`ifdef FIFO_RPTR_AEMPTY_EN
  localparam logic [ADDR_WIDTH:0] AEMPTY_LIMIT = PW'(AEMPTY_THRESH);

  logic aempty_reg, aempty_next;

  // Compare against the next count so that the flag lines up with rcount
  // on the same edge.
  always_comb begin
    aempty_next = (rcount_next <= AEMPTY_LIMIT);
  end

  always_ff @(posedge rclk or negedge r_nrst) begin
    if (!r_nrst) begin
      aempty_reg <= 1'b1;
    end else begin
      aempty_reg <= aempty_next;
    end
  end

  assign almost_empty = aempty_reg;
`else
  // Without the comparator, almost_empty follows empty. This keeps the port
  // meaningful for consumers that only look at almost_empty.
  assign almost_empty = empty_reg;
`endif

  assign rptr      = rptr_reg;
  assign raddr     = rbin_reg[ADDR_WIDTH-1:0];
  assign empty     = empty_reg;
  assign rcount    = rcount_reg;
  assign underflow = underflow_reg;

endmodule
